// File: rtl/fb_scanout_pkg.sv
// Shared constants and fetch-state encoding for the framebuffer scanout block.
// FB_SCAN_DOUBLE_EN selects the 2x (128x64) output geometry.
package fb_scanout_pkg;

    localparam logic [11:0] FB_BASE      = 12'h100;
    localparam int unsigned FB_WIDTH     = 64;
    localparam int unsigned FB_HEIGHT    = 32;
    localparam int unsigned FB_ROW_BYTES = 8;

`ifdef FB_SCAN_DOUBLE_EN
    localparam logic [6:0] OUT_X_MAX = 7'(2 * FB_WIDTH - 1);
    localparam logic [5:0] OUT_Y_MAX = 6'(2 * FB_HEIGHT - 1);
`else
    localparam logic [6:0] OUT_X_MAX = 7'(FB_WIDTH - 1);
    localparam logic [5:0] OUT_Y_MAX = 6'(FB_HEIGHT - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DONE_FETCH
    } fetch_state_t;

endpackage

// File: rtl/fb_byte_serializer.sv
// Byte-to-pixel serializer: one-byte hold register feeding an 8-bit shift register
// with valid/ready output. FB_SCAN_DOUBLE_EN repeats every bit for two handshakes.
module fb_byte_serializer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold_wr,
    input  logic [7:0] hold_data,
    output logic       hold_valid,
    output logic       hold_take,
    input  logic       pix_ready,
    output logic       pix_valid,
    output logic       pix_data,
    output logic       pix_fire
);

    logic [7:0] hold_reg;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       shift_valid;
    logic       bit_adv;

`ifdef FB_SCAN_DOUBLE_EN
    logic phase;
    assign bit_adv = pix_fire & phase;
`else
    assign bit_adv = pix_fire;
`endif

    assign pix_fire  = shift_valid & pix_ready;
    assign pix_valid = shift_valid;
    assign pix_data  = shift_reg[7];
    // Reload on the last bit's handshake so a full hold register keeps 1 pixel/cycle.
    assign hold_take = hold_valid & (~shift_valid | (bit_adv & (bit_cnt == 3'd7)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg    <= '0;
            hold_valid  <= 1'b0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            shift_valid <= 1'b0;
`ifdef FB_SCAN_DOUBLE_EN
            phase       <= 1'b0;
`endif
        end else begin
            if (hold_wr) begin
                hold_reg   <= hold_data;
                hold_valid <= 1'b1;
            end else if (hold_take) begin
                hold_valid <= 1'b0;
            end

            if (hold_take) begin
                shift_reg   <= hold_reg;
                bit_cnt     <= '0;
                shift_valid <= 1'b1;
`ifdef FB_SCAN_DOUBLE_EN
                phase       <= 1'b0;
`endif
            end else if (bit_adv) begin
                shift_reg <= {shift_reg[6:0], 1'b0};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7)
                    shift_valid <= 1'b0;
`ifdef FB_SCAN_DOUBLE_EN
                phase     <= 1'b0;
            end else if (pix_fire) begin
                phase     <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: fetches the 64x32 mono framebuffer byte by byte and streams
// raster-order pixels. FB_SCAN_DOUBLE_EN enables 2x scaling to 128x64.
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter logic [11:0] FB_BASE  = fb_scanout_pkg::FB_BASE,
    parameter int unsigned FB_BYTES = FB_HEIGHT * FB_ROW_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        mem_read,
    output logic [11:0] mem_read_idx,
    input  logic [7:0]  mem_read_byte,
    input  logic        mem_read_ack,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_data,
    output logic [6:0]  pix_x,
    output logic [5:0]  pix_y,
    output logic        pix_first
);

    localparam int unsigned       CNT_W     = $clog2(FB_BYTES);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(FB_BYTES - 1);

    fetch_state_t     state;
    logic [CNT_W-1:0] byte_cnt;
    logic [6:0]       x;
    logic [5:0]       y;
    logic             hold_wr;
    logic             hold_valid;
    logic             hold_take;
    logic             pix_fire;
    logic             last_fire;
`ifdef FB_SCAN_DOUBLE_EN
    logic             second_pass;
`endif

    assign hold_wr   = (state == ST_WAIT) & mem_read_ack;
    assign last_fire = pix_fire & (x == OUT_X_MAX) & (y == OUT_Y_MAX);
    assign pix_x     = x;
    assign pix_y     = y;
    assign pix_first = pix_valid & (x == '0) & (y == '0);

    fb_byte_serializer u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold_wr    (hold_wr),
        .hold_data  (mem_read_byte),
        .hold_valid (hold_valid),
        .hold_take  (hold_take),
        .pix_ready  (pix_ready),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_fire   (pix_fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            byte_cnt     <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            mem_read     <= 1'b0;
            mem_read_idx <= '0;
            x            <= '0;
            y            <= '0;
`ifdef FB_SCAN_DOUBLE_EN
            second_pass  <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            mem_read   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy         <= 1'b1;
                        byte_cnt     <= '0;
                        mem_read     <= 1'b1;
                        mem_read_idx <= FB_BASE;
                        state        <= ST_REQ;
`ifdef FB_SCAN_DOUBLE_EN
                        second_pass  <= 1'b0;
`endif
                    end
                end
                ST_REQ: state <= ST_WAIT;
                ST_WAIT: begin
                    if (mem_read_ack) begin
`ifdef FB_SCAN_DOUBLE_EN
                        // First pass over a row rewinds to its first byte for the repeat.
                        if (byte_cnt[2:0] == 3'd7 && !second_pass) begin
                            byte_cnt    <= byte_cnt - CNT_W'(7);
                            second_pass <= 1'b1;
                            state       <= ST_HOLD;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            if (byte_cnt[2:0] == 3'd7)
                                second_pass <= 1'b0;
                            state <= (byte_cnt == LAST_BYTE && second_pass) ? ST_DONE_FETCH : ST_HOLD;
                        end
`else
                        byte_cnt <= byte_cnt + 1'b1;
                        state    <= (byte_cnt == LAST_BYTE) ? ST_DONE_FETCH : ST_HOLD;
`endif
                    end
                end
                ST_HOLD: begin
                    if (!hold_valid || hold_take) begin
                        mem_read     <= 1'b1;
                        mem_read_idx <= FB_BASE + 12'(byte_cnt);
                        state        <= ST_REQ;
                    end
                end
                ST_DONE_FETCH: ;
                default: state <= ST_IDLE;
            endcase

            if (pix_fire) begin
                if (x == OUT_X_MAX) begin
                    x <= '0;
                    y <= (y == OUT_Y_MAX) ? '0 : y + 6'd1;
                end else begin
                    x <= x + 7'd1;
                end
            end

            if (last_fire) begin
                state      <= ST_IDLE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: memory responder, ready driver, pixel monitor.
// Honors FB_SCAN_DOUBLE_EN to match the RTL build.
module tb_fb_scanout;

`ifdef FB_SCAN_DOUBLE_EN
    localparam int SCALE  = 2;
`else
    localparam int SCALE  = 1;
`endif
    localparam int W      = 64 * SCALE;
    localparam int H      = 32 * SCALE;
    localparam int NREADS = 256 * SCALE;

    typedef struct packed {
        logic       d;
        logic [6:0] x;
        logic [5:0] y;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, frame_done, mem_read;
    logic [11:0] mem_read_idx;
    logic [7:0]  mem_read_byte;
    logic        mem_read_ack;
    logic        pix_valid, pix_ready, pix_data, pix_first;
    logic [6:0]  pix_x;
    logic [5:0]  pix_y;

    fb_scanout dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .frame_done    (frame_done),
        .mem_read      (mem_read),
        .mem_read_idx  (mem_read_idx),
        .mem_read_byte (mem_read_byte),
        .mem_read_ack  (mem_read_ack),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_data      (pix_data),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_first     (pix_first)
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    logic [7:0]  mem [4096];
    pix_t        exp_q[$];
    logic        got_pix [H][W];
    int          lat = 1;
    bit          rmode = 0;
    int          pend = 0;
    logic [11:0] pend_addr;
    int          rd_cnt = 0;
    int          hs_cnt = 0;
    int          fd_cnt = 0;
    bit          stalled = 0;
    logic [15:0] stall_val;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [11:0] exp_addr(input int k);
`ifdef FB_SCAN_DOUBLE_EN
        return 12'(12'h100 + (k / 16) * 8 + k % 8);
`else
        return 12'(12'h100 + k);
`endif
    endfunction

    function automatic logic exp_pix(input int x, input int y);
        int sx, sy;
        logic [7:0] b;
        sx = x / SCALE;
        sy = y / SCALE;
        b  = mem[12'h100 + sy * 8 + sx / 8];
        return b[7 - sx % 8];
    endfunction

    // Memory responder and ready driver, just after each rising edge.
    initial begin
        bit outstanding;
        mem_read_ack  = 1'b0;
        mem_read_byte = '0;
        pix_ready     = 1'b0;
        forever begin
            @(posedge clk); #1;
            outstanding  = (pend > 0);
            mem_read_ack = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_read_ack  = 1'b1;
                    mem_read_byte = mem[pend_addr];
                end
            end
            if (mem_read) begin
                check("rd_overlap", 32'(outstanding), 32'd0);
                check("rd_addr", 32'(mem_read_idx), 32'(exp_addr(rd_cnt)));
                rd_cnt++;
                pend      = lat;
                pend_addr = mem_read_idx;
            end
            pix_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares handshakes against the scoreboard and checks stall stability.
    initial begin
        pix_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
                continue;
            end
            if (frame_done) fd_cnt++;
            if (stalled)
                check("stall_hold", 32'({pix_valid, pix_data, pix_x, pix_y, pix_first}), 32'(stall_val));
            stalled = 0;
            if (pix_valid && pix_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("extra_pixel", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", 32'({busy, pix_first, pix_data, pix_x, pix_y}),
                          32'({1'b1, (e.x == 0 && e.y == 0), e.d, e.x, e.y}));
                end
                got_pix[int'(pix_y)][int'(pix_x)] = pix_data;
            end else if (pix_valid) begin
                stalled   = 1;
                stall_val = {pix_valid, pix_data, pix_x, pix_y, pix_first};
            end
        end
    end

    task automatic fill_expected();
        exp_q.delete();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_q.push_back('{d: exp_pix(x, y), x: 7'(x), y: 6'(y)});
    endtask

    task automatic run_frame(input int l, input bit rm, input bit start_mid, input string name);
        int  n;
        bit  pulsed;
        lat    = l;
        rmode  = rm;
        hs_cnt = 0;
        rd_cnt = 0;
        fd_cnt = 0;
        pulsed = 0;
        fill_expected();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check({name, "_busy_rise"}, 32'(busy), 32'd1);
        n = 0;
        while (!frame_done && n < W * H * 4 + NREADS * 20) begin
            @(negedge clk);
            if (start_mid && !pulsed && hs_cnt >= 100) begin
                start  = 1'b1;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
            n++;
        end
        start = 1'b0;
        check({name, "_done_seen"}, 32'(frame_done), 32'd1);
        check({name, "_busy_drop"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check({name, "_handshakes"}, 32'(hs_cnt), 32'(W * H));
        check({name, "_reads"}, 32'(rd_cnt), 32'(NREADS));
        check({name, "_done_pulses"}, 32'(fd_cnt), 32'd1);
        check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_directed(input string name);
        logic [7:0] pat;
`ifdef FB_SCAN_DOUBLE_EN
        pat = 8'h80;
        check({name, "_p00"}, 32'(got_pix[0][0]), 32'd1);
        check({name, "_p10"}, 32'(got_pix[0][1]), 32'd1);
        check({name, "_p01"}, 32'(got_pix[1][0]), 32'd1);
        check({name, "_p11"}, 32'(got_pix[1][1]), 32'd1);
        check({name, "_p20"}, 32'(got_pix[0][2]), 32'd0);
        check({name, "_p02"}, 32'(got_pix[2][0]), 32'(pat[7]));
`else
        pat = 8'hC3;
        for (int x = 0; x < 8; x++) begin
            check({name, "_row0"}, 32'(got_pix[0][x]), 32'd1);
            check({name, "_row1"}, 32'(got_pix[1][x]), 32'(pat[7 - x]));
        end
        check({name, "_row0_x8"}, 32'(got_pix[0][8]), 32'd0);
`endif
    endtask

    initial begin
        int n;
        bit quiet;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
`ifdef FB_SCAN_DOUBLE_EN
        mem[12'h100] = 8'h80;
`else
        mem[12'h100] = 8'hFF;
`endif
        mem[12'h108] = 8'hC3;
        start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({busy, frame_done, mem_read, mem_read_idx, pix_valid, pix_data, pix_x, pix_y, pix_first}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(1, 0, 0, "basic");
        check_directed("basic");

        run_frame(1, 1, 0, "backpressure");
        check_directed("backpressure");

        mem[12'h1FF] = 8'h01;
        run_frame(12, 0, 0, "slow_mem");

        run_frame(1, 0, 1, "start_busy");
        run_frame(1, 0, 0, "second_frame");

        // Reset mid-frame with a read outstanding; its ack lands after reset.
        lat    = 5;
        rmode  = 0;
        hs_cnt = 0;
        rd_cnt = 0;
        fill_expected();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!(hs_cnt >= 500 && pend > 1) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_500", 32'(hs_cnt >= 500 && pend > 1), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              32'({busy, frame_done, mem_read, mem_read_idx, pix_valid, pix_data, pix_x, pix_y, pix_first}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        quiet = 1;
        repeat (15) begin
            @(negedge clk);
            if (mem_read || pix_valid || busy || frame_done) quiet = 0;
        end
        check("rst_late_ack_ignored", 32'(quiet), 32'd1);
        run_frame(1, 0, 0, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
